// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction BRAM.
// DEPTH_WORDS lives here so the loader's capacity check and the BRAM depth agree.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } imem_ld_state_t;

  localparam int unsigned BYTES_PER_WORD   = 4;
  localparam int unsigned WORD_BYTES_LOG2  = 2;
  localparam int unsigned IMEM_DEPTH_WORDS = 1024;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Packs a big-endian byte stream into 32-bit words; word_valid_o fires on the
// accept of the last byte of a word, with word_o already holding the full word.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [WORD_BYTES_LOG2-1:0] idx_q;
  logic [31:0]                word_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      idx_q <= '0;
    end else if (byte_en_i) begin
      idx_q <= idx_q + WORD_BYTES_LOG2'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
    end else if (byte_en_i) begin
      word_q <= word_o;
    end
  end

  // Earlier bytes shift toward the MSBs, so the first byte ends in bits 31:24.
  always_comb begin
    word_o       = {word_q[23:0], byte_i};
    word_valid_o = byte_en_i && (idx_q == WORD_BYTES_LOG2'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a length-prefixed byte stream and holds the
// CPU in reset until the program has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_ena,
  output logic        mem_wea,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_written
);

  imem_ld_state_t state_q, state_d;
  logic [15:0]    count_q;
  logic [15:0]    words_q;
  logic [15:0]    words_inc;
  logic [15:0]    count_new;
  logic [31:0]    mem_addr_q;
  logic [31:0]    mem_din_q;
  logic [31:0]    packed_word;
  logic           word_valid;
  logic           accept;
  logic           rearm;

  assign accept    = in_valid && in_ready;
  assign rearm     = start && ((state_q == ST_DONE) || (state_q == ST_ERROR));
  assign words_inc = words_q + 16'd1;
  assign count_new = {count_q[15:8], in_data};

  byte_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (rearm),
    .byte_en_i    (accept && (state_q == ST_DATA)),
    .byte_i       (in_data),
    .word_o       (packed_word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CNT_HI;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CNT_HI: if (accept) state_d = ST_CNT_LO;
      ST_CNT_LO: begin
        if (accept) begin
          if (count_new == 16'd0)                   state_d = ST_DONE;
          else if (32'(count_new) > DEPTH_WORDS)    state_d = ST_ERROR;
          else                                      state_d = ST_DATA;
        end
      end
      ST_DATA:   if (word_valid) state_d = ST_WRITE;
      ST_WRITE:  state_d = (words_inc == count_q) ? ST_DONE : ST_DATA;
      ST_DONE,
      ST_ERROR:  if (start) state_d = ST_CNT_HI;
      default:   state_d = ST_CNT_HI;
    endcase
  end

  // Address and data are captured on the last byte's accept edge so they are
  // already stable during the single WRITE cycle and hold afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      words_q    <= '0;
      mem_addr_q <= BASE_ADDR;
      mem_din_q  <= '0;
    end else begin
      if (accept && (state_q == ST_CNT_HI)) count_q[15:8] <= in_data;
      if (accept && (state_q == ST_CNT_LO)) count_q[7:0]  <= in_data;
      if (word_valid) begin
        mem_din_q  <= packed_word;
        mem_addr_q <= BASE_ADDR + (32'(words_q) << WORD_BYTES_LOG2);
      end
      if (state_q == ST_WRITE) words_q <= words_inc;
      if (rearm)               words_q <= '0;
    end
  end

  always_comb begin
    in_ready      = !reset && ((state_q == ST_CNT_HI) || (state_q == ST_CNT_LO) ||
                               (state_q == ST_DATA));
    mem_ena       = (state_q == ST_WRITE);
    mem_wea       = (state_q == ST_WRITE);
    mem_addr      = mem_addr_q;
    mem_din       = mem_din_q;
    cpu_hold      = (state_q != ST_DONE);
    load_done     = (state_q == ST_DONE);
    load_error    = (state_q == ST_ERROR);
    words_written = words_q;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory port. Fetch only reads instruction memory; this block fills it.
- Receives a program as a byte stream over a valid/ready handshake from an upstream UART or host bridge.
- Assembles the bytes into 32-bit big-endian words and writes them sequentially into the instruction BRAM write port (ena/wea/addra/dina).
- Holds the CPU in reset via cpu_hold until the load completes.

Parameters:
- DEPTH_WORDS, 1024, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; re-arms the loader from DONE or ERROR
- in_data  input  8  stream byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts a byte this cycle
- mem_ena  output  1  BRAM port enable
- mem_wea  output  1  BRAM write enable
- mem_addr  output  32  BRAM byte address (word-aligned; same byte addressing fetch uses)
- mem_din  output  32  BRAM write data
- cpu_hold  output  1  high means the CPU/PC is held in reset
- load_done  output  1  high while in DONE
- load_error  output  1  high while in ERROR
- words_written  output  16  count of words committed in the current load

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Byte transfer: a byte transfers on a rising edge where in_valid && in_ready. in_ready is forced 0 while reset is high.
- Stream format: 16-bit word count N, big-endian (high byte first), followed by 4*N data bytes. Each word is big-endian: the first byte goes to bits 31:24.
- States: CNT_HI, CNT_LO, DATA, WRITE, DONE, ERROR. in_ready=1 only in CNT_HI, CNT_LO and DATA.
- Reset values: state=CNT_HI, mem_ena=0, mem_wea=0, mem_addr=BASE_ADDR, mem_din=0, cpu_hold=1, load_done=0, load_error=0, words_written=0. Internal byte index=0.
- CNT_HI: on accept, latch count[15:8] and go to CNT_LO.
- CNT_LO: on accept, latch count[7:0], then:
  - N==0 goes to DONE.
  - N>DEPTH_WORDS goes to ERROR.
  - Otherwise goes to DATA.
- DATA: on accept, shift the byte into the word register and increment the byte index (2 bits). On the 4th byte accept (index 3), go to WRITE.
- WRITE (exactly 1 cycle, in_ready=0):
  - mem_ena=mem_wea=1, mem_din=assembled word, mem_addr=BASE_ADDR+4*words_written.
  - Next edge: words_written+1. If the new count==N, go to DONE; else go to DATA.
  - Write latency: the BRAM write strobe is the cycle immediately after the 4th byte's accept edge.
- mem_ena and mem_wea are high only in WRITE; 0 otherwise. Loader reads are not supported.
- mem_addr and mem_din hold their last values outside WRITE.
- DONE: cpu_hold=0, load_done=1, in_ready=0. Bytes on in_data are ignored.
- ERROR: cpu_hold=1, load_error=1, in_ready=0.
- start handling:
  - In DONE or ERROR, start goes to CNT_HI, clears words_written and the byte index, and sets cpu_hold=1 the next cycle.
  - start is ignored in all other states.
- Arithmetic: address math is 32-bit and wraps modulo 2^32. words_written is never compared beyond 16 bits.
- Reset mid-load returns to the reset values. Words already written stay in BRAM; they are not cleared.
- in_valid may drop between bytes. The loader waits indefinitely; there is no timeout.

Decomposition:
- Shared package holds:
  - the state enumeration typedef (imem_ld_state_t);
  - BYTES_PER_WORD=4 and WORD_BYTES_LOG2=2;
  - the default DEPTH_WORDS constant, shared with the instruction-memory instantiation so the capacity check and the BRAM depth agree.
- One natural sub-module: byte_word_packer (byte index counter plus 32-bit shift register with a word_valid strobe). The FSM, address generation and cpu_hold stay in imem_loader.

Test Plan:
- Load N=2: bytes 00 02 DE AD BE EF 12 34 56 78 -> two WRITE cycles with mem_addr=0/mem_din=DEADBEEF and mem_addr=4/mem_din=12345678; then load_done=1, cpu_hold=0, words_written=2.
- N=0: bytes 00 00 -> DONE directly after the 2nd accept; no mem_wea pulse; cpu_hold=0.
- N=DEPTH_WORDS+1 (e.g. 04 01 with 1024) -> ERROR, load_error=1, cpu_hold=1, in_ready=0. A start pulse then returns to CNT_HI with in_ready=1.
- Backpressure and gaps: in_valid toggled randomly during N=1 -> the word is still AABBCCDD for bytes AA BB CC DD. in_ready=0 exactly in the WRITE cycle, and no byte is lost or duplicated.
- Reset asserted after 2 data bytes of the 2nd word -> next cycle all outputs at reset values. A fresh N=1 load then writes to address BASE_ADDR (0), and words_written reads 1.
- start pulsed mid-DATA -> ignored. The load completes normally with the correct count.
